// File: rtl/dual_edge_event_arbiter.sv
// dual_edge_event_arbiter
// Detects rising and falling edges on N synchronous level inputs. Each edge is
// held as one pending event per channel. A round-robin scheduler drains the
// pending events onto a single valid/ready event port that carries the channel
// index and the edge polarity. A sticky per-channel overflow flag records any
// edge that had to be dropped because its channel already held an event.
module dual_edge_event_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   level,
   input  logic [N-1:0]   en,
   input  logic           ev_ready,
   output logic           ev_valid,
   output logic [IDW-1:0] ev_id,
   output logic           ev_rise,
   input  logic           ovf_clr,
   output logic [N-1:0]   overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_VALID = 2'd1
   } state_t;

   state_t         state_q;

   // Edge-detection and per-channel event storage
   logic [N-1:0]   level_q;
   logic [N-1:0]   pending_q;
   logic [N-1:0]   pending_d;
   logic [N-1:0]   pend_rise_q;
   logic [N-1:0]   pend_rise_d;
   logic [N-1:0]   overflow_q;
   logic [N-1:0]   overflow_d;

   // Output event register and round-robin pointer
   logic           ev_valid_q;
   logic [IDW-1:0] ev_id_q;
   logic           ev_rise_q;
   logic [IDW-1:0] ptr_q;

   // Combinational helpers
   logic [N-1:0]   edge_det;
   logic [N-1:0]   load_vec;
   logic [N-1:0]   ovf_set;
   logic [N-1:0]   capture;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] grant_hi;
   logic [IDW-1:0] grant_lo;
   logic           found_hi;
   logic [IDW-1:0] ptr_next;
   logic           any_pend;
   logic           can_load;
   logic           load;

   // An edge is any difference from last cycle's level on an enabled channel.
   // level_q tracks the input even while disabled, so re-enabling is silent.
   assign edge_det = (level ^ level_q) & en;
   assign any_pend = |pending_q;

   // Round-robin grant: the lowest pending index at or above ptr wins; if none,
   // the lowest pending index below ptr wins (the wrapped part of the search).
   always_comb begin
      grant_hi = '0;
      grant_lo = '0;
      found_hi = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            if (i >= int'(ptr_q)) begin
               grant_hi = IDW'(i);
               found_hi = 1'b1;
            end else begin
               grant_lo = IDW'(i);
            end
         end
      end
      grant = found_hi ? grant_hi : grant_lo;
   end

   // The pointer moves one past the granted channel, wrapping at N-1 (N need
   // not be a power of two, so the wrap is explicit).
   assign ptr_next = (int'(grant) == N - 1) ? '0 : grant + IDW'(1);

   // The output register can take a new event when empty or when the current
   // one is being handed over in this cycle.
   assign can_load = (state_q == S_IDLE) || ((state_q == S_VALID) && ev_ready);
   assign load     = can_load && any_pend;
   assign load_vec = load ? (N'(1) << grant) : '0;

   // A new edge is dropped only if its channel holds an event that is not
   // leaving for the output register in this same cycle.
   assign ovf_set  = edge_det & pending_q & ~load_vec;
   assign capture  = edge_det & ~ovf_set;

   // Next-state for the pending bits, their polarity and the overflow flags.
   always_comb begin
      pending_d   = en & ((pending_q & ~load_vec) | edge_det);
      pend_rise_d = (pend_rise_q & ~capture) | (level & capture);
      overflow_d  = ovf_clr ? ovf_set : (overflow_q | ovf_set);
   end

   // Per-channel state: sampled levels, pending events and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q     <= '0;
         pending_q   <= '0;
         pend_rise_q <= '0;
         overflow_q  <= '0;
      end else begin
         level_q     <= level;
         pending_q   <= pending_d;
         pend_rise_q <= pend_rise_d;
         overflow_q  <= overflow_d;
      end
   end

   // Output FSM: presents one event at a time and reloads on handshake so
   // that back-to-back events stream at one per clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ev_valid_q <= 1'b0;
         ev_id_q    <= '0;
         ev_rise_q  <= 1'b0;
         ptr_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  state_q    <= S_VALID;
                  ev_valid_q <= 1'b1;
                  ev_id_q    <= grant;
                  ev_rise_q  <= pend_rise_q[grant];
                  ptr_q      <= ptr_next;
               end
            end
            S_VALID: begin
               if (ev_ready) begin
                  if (load) begin
                     ev_id_q    <= grant;
                     ev_rise_q  <= pend_rise_q[grant];
                     ptr_q      <= ptr_next;
                  end else begin
                     state_q    <= S_IDLE;
                     ev_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q    <= S_IDLE;
               ev_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_id    = ev_id_q;
   assign ev_rise  = ev_rise_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_dual_edge_event_arbiter.sv
// Testbench for dual_edge_event_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared each cycle against a
// behavioural model of the event arbiter.
module tb_dual_edge_event_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic           clk;
   logic           reset;
   logic [N-1:0]   level;
   logic [N-1:0]   en;
   logic           ev_ready;
   logic           ev_valid;
   logic [IDW-1:0] ev_id;
   logic           ev_rise;
   logic           ovf_clr;
   logic [N-1:0]   overflow;

   int tests = 0;
   int fails = 0;

   dual_edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
      .clk      (clk),
      .reset    (reset),
      .level    (level),
      .en       (en),
      .ev_ready (ev_ready),
      .ev_valid (ev_valid),
      .ev_id    (ev_id),
      .ev_rise  (ev_rise),
      .ovf_clr  (ovf_clr),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state: the presented event, one pending slot per
   // channel (with polarity), the overflow flags, the last seen levels and
   // the round-robin start index.
   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
      logic           rise;
      int             ptr;
      logic [N-1:0]   pend;
      logic [N-1:0]   prise;
      logic [N-1:0]   ovf;
      logic [N-1:0]   prev;
   } mstate_t;

   mstate_t ms;

   function automatic mstate_t model_step(mstate_t s, logic [N-1:0] lv, logic [N-1:0] e,
                                          logic rdy, logic clr);
      mstate_t      n;
      int           g;
      logic         free;
      logic         loaded;
      logic [N-1:0] setv;
      n    = s;
      g    = -1;
      setv = '0;
      for (int k = 0; k < N; k++) begin
         if (g < 0 && s.pend[(s.ptr + k) % N]) g = (s.ptr + k) % N;
      end
      free   = !s.valid || rdy;
      loaded = free && (g >= 0);
      if (free) begin
         n.valid = loaded;
         if (loaded) begin
            n.id   = IDW'(g);
            n.rise = s.prise[g];
            n.ptr  = (g + 1) % N;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!e[i]) begin
            n.pend[i] = 1'b0;
         end else if (lv[i] != s.prev[i]) begin
            if (!s.pend[i] || (loaded && g == i)) begin
               n.pend[i]  = 1'b1;
               n.prise[i] = lv[i];
            end else begin
               setv[i] = 1'b1;
            end
         end else if (loaded && g == i) begin
            n.pend[i] = 1'b0;
         end
      end
      n.ovf  = clr ? setv : (s.ovf | setv);
      n.prev = lv;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) ms <= '0;
      else       ms <= model_step(ms, level, en, ev_ready, ovf_clr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model comparison on every falling edge while out of reset.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         chk("model_valid", 32'(ev_valid), 32'(ms.valid));
         if (ms.valid) begin
            chk("model_id", 32'(ev_id), 32'(ms.id));
            chk("model_rise", 32'(ev_rise), 32'(ms.rise));
         end
         chk("model_ovf", 32'(overflow), 32'(ms.ovf));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      level    = '0;
      en       = '0;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      level    = '0;
      en       = '0;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;

      // Single channel rise then fall
      do_reset();
      chk("rst_valid", 32'(ev_valid), 0);
      chk("rst_id", 32'(ev_id), 0);
      chk("rst_rise", 32'(ev_rise), 0);
      chk("rst_ovf", 32'(overflow), 0);
      en = 4'b0001; ev_ready = 1'b1; level = 4'b0001;
      tick(); chk("s1_lat", 32'(ev_valid), 0);
      tick(); chk("s1_valid", 32'(ev_valid), 1);
      chk("s1_id", 32'(ev_id), 0); chk("s1_rise", 32'(ev_rise), 1);
      tick(); chk("s1_idle", 32'(ev_valid), 0);
      tick(); level = 4'b0000;
      tick(); chk("s1_lat2", 32'(ev_valid), 0);
      tick(); chk("s1_valid2", 32'(ev_valid), 1);
      chk("s1_id2", 32'(ev_id), 0); chk("s1_rise2", 32'(ev_rise), 0);
      chk("s1_ovf", 32'(overflow), 0);

      // Fairness: all channels at once, twice
      do_reset();
      en = 4'hF; ev_ready = 1'b1; level = 4'hF;
      tick(); tick();
      for (int k = 0; k < N; k++) begin
         chk("rr_valid", 32'(ev_valid), 1);
         chk("rr_id", 32'(ev_id), 32'(k));
         chk("rr_rise", 32'(ev_rise), 1);
         tick();
      end
      chk("rr_done", 32'(ev_valid), 0);
      level = 4'h0;
      tick(); tick();
      for (int k = 0; k < N; k++) begin
         chk("rr2_id", 32'(ev_id), 32'(k));
         chk("rr2_rise", 32'(ev_rise), 0);
         tick();
      end
      chk("rr2_done", 32'(ev_valid), 0);

      // Backpressure and overflow
      do_reset();
      en = 4'hF; ev_ready = 1'b0; level = 4'b0001;
      tick(); tick();
      chk("bp_occ_valid", 32'(ev_valid), 1); chk("bp_occ_id", 32'(ev_id), 0);
      level = 4'b0101; tick();
      level = 4'b0001; tick();
      chk("bp_ovf", 32'(overflow), 32'h4);
      chk("bp_hold_id", 32'(ev_id), 0);
      ev_ready = 1'b1; tick();
      chk("bp_id", 32'(ev_id), 2); chk("bp_rise", 32'(ev_rise), 1);
      tick(); chk("bp_single", 32'(ev_valid), 0);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("bp_clr", 32'(overflow), 0);
      ev_ready = 1'b0; level = 4'b0101;
      tick(); tick();
      chk("bp2_id", 32'(ev_id), 2); chk("bp2_rise", 32'(ev_rise), 1);
      level = 4'b0001; tick();
      level = 4'b0101; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("bp_set_over_clr", 32'(overflow), 32'h4);
      ev_ready = 1'b1; tick(); tick(); tick();

      // Enable masking
      do_reset();
      en = 4'b1101; ev_ready = 1'b1; level = 4'b0010;
      tick(); tick(); tick();
      chk("en_masked", 32'(ev_valid), 0);
      en = 4'hF; tick(); tick(); tick();
      chk("en_reenable", 32'(ev_valid), 0);
      level = 4'b0000; tick(); tick();
      chk("en_valid", 32'(ev_valid), 1);
      chk("en_id", 32'(ev_id), 1); chk("en_rise", 32'(ev_rise), 0);
      tick(); chk("en_idle", 32'(ev_valid), 0);
      ev_ready = 1'b0; level = 4'b0001; tick(); tick();
      chk("en_occ_id", 32'(ev_id), 0);
      level = 4'b0011; tick();
      en = 4'b1101; tick();
      en = 4'hF; ev_ready = 1'b1; tick();
      chk("en_discard", 32'(ev_valid), 0);
      tick(); chk("en_discard2", 32'(ev_valid), 0);

      // Edge in the same cycle as the channel's load
      do_reset();
      en = 4'hF; ev_ready = 1'b1; level = 4'b1000;
      tick(); level = 4'b0000;
      tick(); chk("co_id", 32'(ev_id), 3); chk("co_rise", 32'(ev_rise), 1);
      tick(); chk("co_valid2", 32'(ev_valid), 1);
      chk("co_id2", 32'(ev_id), 3); chk("co_rise2", 32'(ev_rise), 0);
      chk("co_ovf", 32'(overflow), 0);
      tick(); chk("co_idle", 32'(ev_valid), 0);

      // Asynchronous reset in the middle of traffic
      do_reset();
      en = 4'hF; ev_ready = 1'b0; level = 4'b0111;
      tick(); tick();
      chk("mr_valid", 32'(ev_valid), 1); chk("mr_id", 32'(ev_id), 0);
      level = 4'b0101; tick();
      chk("mr_ovf", 32'(overflow), 32'h2);
      #2 reset = 1'b1;
      #1;
      chk("mr_async_valid", 32'(ev_valid), 0);
      chk("mr_async_ovf", 32'(overflow), 0);
      chk("mr_async_id", 32'(ev_id), 0);
      tick(); reset = 1'b0; ev_ready = 1'b1;
      tick(); chk("mr_lat", 32'(ev_valid), 0);
      tick(); chk("mr_id0", 32'(ev_id), 0); chk("mr_rise0", 32'(ev_rise), 1);
      tick(); chk("mr_id2", 32'(ev_id), 2); chk("mr_rise2", 32'(ev_rise), 1);
      tick(); chk("mr_idle", 32'(ev_valid), 0);

      // Randomized traffic against the model
      do_reset();
      en = 4'hF;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
         level    = level ^ (N'($urandom) & N'($urandom));
         if ($urandom_range(0, 19) == 0) en = N'($urandom | $urandom);
         ev_ready = ($urandom_range(0, 3) != 0);
         ovf_clr  = ($urandom_range(0, 15) == 0);
      end
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
